// File: rtl/rr_output_arbiter_pkg.sv
// rr_output_arbiter_pkg: shared port indices, default port count and port vector type
package rr_output_arbiter_pkg;
  localparam int DEF_PORTS = 5;
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;
  typedef logic [DEF_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/rr_output_arbiter_if.sv
// rr_output_arbiter_if: request/flit-flag/handshake bundle between requesters and one output arbiter
// slave modport: arbiter side (req, tail, dcts in; grant, xbar_sel, rts, busy out)
// master modport: requester/downstream side, mirror of slave
interface rr_output_arbiter_if
  import rr_output_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_PORTS
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] tail;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] xbar_sel;
  logic dcts;
  logic rts;
  logic busy;
  modport slave (input req, tail, dcts, output grant, xbar_sel, rts, busy);
  modport master (output req, tail, dcts, input grant, xbar_sel, rts, busy);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: one-hot winner of req, searching upward from index start with wraparound
// ports: req (requests), start (first index searched), win (one-hot winner, zero when no req)
module rr_priority_pick #(
  parameter int N = 5,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  win
);
  logic [N-1:0] rot;
  logic [N-1:0] first;
  // rotate so start lands at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    rot = N'({req, req} >> start);
    first = rot & (~rot + 1'b1);
    win = N'(({first, first} << start) >> N);
  end
endmodule

// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter: rotating-priority output arbiter with registered RTS/DCTS handshake
// ports: clk, rst (async, active high), bus (slave: req, tail, dcts in; grant, xbar_sel, rts, busy out)
module rr_output_arbiter
  import rr_output_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_PORTS,
  parameter bit LOCK_ON_TAIL = 1'b0
) (
  input logic clk,
  input logic rst,
  rr_output_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0] owner;
  logic [NUM_PORTS-1:0] next_owner;
  logic [SW-1:0] start;
  logic rts;
  logic xfer;
  logic hold;
  // idle searches from the last (local) port so it wins first, then wraps to 0
  always_comb begin
    start = SW'(NUM_PORTS - 1);
    for (int i = 0; i < NUM_PORTS; i++) start = owner[i] ? SW'(i) : start;
  end
  rr_priority_pick #(.N(NUM_PORTS)) u_pick (
    .req(bus.req),
    .start(start),
    .win(next_owner)
  );
  assign xfer = rts & bus.dcts;
  // lock mode only lets go when the owner's tail flit actually moves
  assign hold = (rts & ~bus.dcts) | (LOCK_ON_TAIL && (|owner) && !(xfer && (|(bus.tail & owner))));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
      rts <= 1'b0;
    end else begin
      owner <= hold ? owner : next_owner;
      rts <= (|owner) & ~xfer;
    end
  end
  assign bus.grant = owner & {NUM_PORTS{xfer}};
  assign bus.xbar_sel = owner;
  assign bus.rts = rts;
  assign bus.busy = |owner;
endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb_rr_output_arbiter: random and directed checks of three arbiter configurations against an index-level model
module tb_rr_output_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] req8;
  logic [7:0] tail8;
  logic dcts;
  logic fair_en;
  logic [7:0] last_gc = '0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;

  rr_output_arbiter_if #(.NUM_PORTS(5)) ifa ();
  rr_output_arbiter_if #(.NUM_PORTS(5)) ifb ();
  rr_output_arbiter_if #(.NUM_PORTS(8)) ifc ();
  assign ifa.req = req8[4:0];
  assign ifa.tail = tail8[4:0];
  assign ifa.dcts = dcts;
  assign ifb.req = req8[4:0];
  assign ifb.tail = tail8[4:0];
  assign ifb.dcts = dcts;
  assign ifc.req = req8;
  assign ifc.tail = tail8;
  assign ifc.dcts = dcts;

  rr_output_arbiter #(.NUM_PORTS(5), .LOCK_ON_TAIL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rr_output_arbiter #(.NUM_PORTS(5), .LOCK_ON_TAIL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  rr_output_arbiter #(.NUM_PORTS(8), .LOCK_ON_TAIL(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic [4:0] p_req;
  logic [2:0] p_start;
  logic [4:0] p_win;
  rr_priority_pick #(.N(5)) u_pk (.req(p_req), .start(p_start), .win(p_win));

  logic [7:0] g [3];
  logic [7:0] x [3];
  logic rt [3];
  logic bz [3];
  assign g[0] = {3'b0, ifa.grant};
  assign g[1] = {3'b0, ifb.grant};
  assign g[2] = ifc.grant;
  assign x[0] = {3'b0, ifa.xbar_sel};
  assign x[1] = {3'b0, ifb.xbar_sel};
  assign x[2] = ifc.xbar_sel;
  assign rt[0] = ifa.rts;
  assign rt[1] = ifb.rts;
  assign rt[2] = ifc.rts;
  assign bz[0] = ifa.busy;
  assign bz[1] = ifb.busy;
  assign bz[2] = ifc.busy;

  // model: owner as an index (-1 = idle), rts as a flag
  int n_p [3] = '{5, 5, 8};
  bit lk [3] = '{1'b0, 1'b1, 1'b0};
  int own [3] = '{-1, -1, -1};
  int nown [3] = '{-1, -1, -1};
  bit mr [3] = '{1'b0, 1'b0, 1'b0};
  bit nmr [3] = '{1'b0, 1'b0, 1'b0};
  int fc [8] = '{0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int n, input int o);
    int s = (o < 0) ? n - 1 : o;
    for (int k = 0; k < n; k++) if (r[(s + k) % n]) return (s + k) % n;
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [7:0] ex;
    logic [7:0] eg;
    bit inv;
    for (int k = 0; k < 3; k++) begin
      ex = (own[k] < 0) ? 8'd0 : (8'd1 << own[k]);
      eg = (mr[k] && dcts && own[k] >= 0) ? ex : 8'd0;
      chk($sformatf("out%0d", k), {g[k], x[k], 6'b0, rt[k], bz[k]}, {eg, ex, 6'b0, mr[k], own[k] >= 0});
      inv = $onehot0(g[k]) && $onehot0(x[k]) && ((g[k] & ~x[k]) == 8'd0) && (rt[k] || g[k] == 8'd0);
      chk($sformatf("inv%0d", k), inv, 1);
      if (mr[k] && !dcts) nown[k] = own[k];
      else if (lk[k] && own[k] >= 0 && !(mr[k] && dcts && tail8[own[k]])) nown[k] = own[k];
      else nown[k] = pick(req8, n_p[k], own[k]);
      nmr[k] = (own[k] >= 0) && !(mr[k] && dcts);
    end
    for (int p = 0; p < 8; p++) begin
      if (!fair_en || !req8[p] || g[2][p]) fc[p] = 0;
      else if (|g[2]) fc[p]++;
      if (fair_en && req8[p]) chk($sformatf("fair%0d", p), fc[p] <= 8, 1);
    end
    last_gc = g[2];
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      own[k] = rst ? -1 : nown[k];
      mr[k] = rst ? 1'b0 : nmr[k];
    end
  end

  task automatic step(input logic [7:0] r, input logic [7:0] t, input logic d);
    req8 = r;
    tail8 = t;
    dcts = d;
    @(posedge clk);
    #1;
  endtask

  initial begin : drv
    logic [7:0] nr;
    int m;
    rst = 1'b1;
    req8 = '0;
    tail8 = '0;
    dcts = 1'b0;
    fair_en = 1'b0;
    for (int s = 0; s < 5; s++)
      for (int r = 0; r < 32; r++) begin
        p_req = 5'(r);
        p_start = 3'(s);
        #1;
        m = pick({3'b0, p_req}, 5, s);
        chk("pick", p_win, (m < 0) ? 5'd0 : (5'd1 << m));
      end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_state", {ifa.grant, ifa.xbar_sel, ifa.rts, ifa.busy}, 0);
    step(8'b10001, 8'h00, 1'b0);
    chk("idle_local", ifa.xbar_sel, 5'b10000);
    step(8'b10001, 8'h00, 1'b0);
    chk("rts_up", ifa.rts, 1);
    req8 = 8'b00001;
    dcts = 1'b1;
    #1 chk("grant_local", ifa.grant, 5'b10000);
    step(8'b00001, 8'h00, 1'b1);
    chk("wrap_north", ifa.xbar_sel, 5'b00001);
    chk("gap_rts", ifa.rts, 0);
    step(8'b00001, 8'h00, 1'b0);
    chk("stall_start", {ifa.xbar_sel, ifa.rts}, {5'b00001, 1'b1});
    repeat (4) begin
      step(8'($urandom_range(31)), 8'h00, 1'b0);
      chk("stall_hold", {ifa.grant, ifa.xbar_sel, ifa.rts}, {5'b00000, 5'b00001, 1'b1});
    end
    req8 = 8'b00001;
    dcts = 1'b1;
    #1 chk("stall_release", ifa.grant, 5'b00001);
    step(8'b00001, 8'h00, 1'b1);
    chk("single_pulse", {ifa.grant, ifa.rts}, 0);
    step(8'b00001, 8'h00, 1'b1);
    chk("pre_reset_grant", ifa.grant, 5'b00001);
    #1 rst = 1'b1;
    #1 chk("async_reset", {ifa.grant, ifa.xbar_sel, ifa.rts, ifa.busy}, 0);
    rst = 1'b0;
    repeat (3) step(8'b00010, 8'h00, 1'b1);
    chk("owner_east", ifa.xbar_sel, 5'b00010);
    step(8'b11101, 8'h00, 1'b1);
    chk("east_to_west", ifa.xbar_sel, 5'b00100);
    step(8'b00011, 8'h00, 1'b1);
    chk("west_wraps_north", ifa.xbar_sel, 5'b00001);
    step(8'b11111, 8'h00, 1'b1);
    chk("north_keeps", ifa.xbar_sel, 5'b00001);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    step(8'b01000, 8'h00, 1'b0);
    chk("lock_owner_s", ifb.xbar_sel, 5'b01000);
    repeat (7) begin
      step(8'b11111, 8'h00, 1'b1);
      chk("lock_hold", ifb.xbar_sel, 5'b01000);
    end
    chk("lock_rts", ifb.rts, 1);
    step(8'b10111, 8'b01000, 1'b1);
    chk("tail_release", ifb.xbar_sel, 5'b10000);
    step(8'b00111, 8'b10000, 1'b0);
    chk("tail_no_xfer", ifb.xbar_sel, 5'b10000);
    fair_en = 1'b1;
    repeat (10000) begin
      nr = req8 & ~last_gc;
      for (int p = 0; p < 8; p++)
        if (nr[p]) begin
          if ($urandom_range(7) == 0) nr[p] = 1'b0;
        end else if (!last_gc[p] && $urandom_range(2) == 0) nr[p] = 1'b1;
      step(nr, 8'($urandom) & 8'($urandom), 1'($urandom_range(1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
